// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address check for the data-memory responder
//
// Purpose:
//   Common definitions used by data_mem_responder and dmem_array.
//   - state_e  : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_W   : data word width in bits
//   - STRB_W   : number of byte lanes per word
//   - addr_ok  : alignment and range check for a byte address
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // A byte address is usable when it is word aligned and every bit above
   // the word index is zero. A shift is used for the upper-bit test so the
   // check works for any array depth without a variable part-select.
   function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                    input int unsigned       aw);
      logic aligned;
      logic in_range;
      aligned  = (addr[1:0] == 2'b00);
      in_range = ((addr >> (aw + 2)) == '0);
      return aligned && in_range;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-enabled synchronous word RAM with registered read
//
// Purpose:
//   2**ADDR_WIDTH x 32-bit storage. Writes update only the byte lanes whose
//   enable bit is set. The read port is registered: rdata shows the word at
//   addr as it was before the same edge's write (read-first). No reset; the
//   contents are undefined until written.
//
// Ports:
//   clk    in   clock, all activity on the rising edge
//   we     in   write enable
//   be     in   byte-lane enables, bit i covers wdata[8i+7:8i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [STRB_W-1:0]     be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (be[i]) begin
               mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with programmable wait states
//
// Purpose:
//   Accepts one word request at a time from the load/store unit, waits
//   LATENCY cycles, performs the access on an internal dmem_array and
//   returns the result on a response channel held until consumed.
//
// Parameters:
//   ADDR_WIDTH  word-address bits; array holds 2**ADDR_WIDTH words
//   LATENCY     wait cycles between acceptance and access (0..15)
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-high reset of the control state
//   req_valid   in   request present
//   req_ready   out  responder idle and able to accept
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   req_wstrb   in   store byte-lane enables
//   resp_valid  out  response present
//   resp_ready  in   consumer takes the response
//   resp_rdata  out  load data, 0 for stores and errors
//   resp_error  out  misaligned or out-of-range request
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_error
);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q,   cnt_d;
   logic              write_q, write_d;
   logic [WORD_W-1:0] addr_q,  addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              err_q,   err_d;

   logic              access;
   logic              addr_good;
   logic              arr_we;
   logic [WORD_W-1:0] arr_rdata;

   // The full 32-bit latched address is checked so any stray upper bit
   // flags an error instead of aliasing onto a low word.
   assign addr_good = addr_ok(addr_q, ADDR_WIDTH);

   // Last wait cycle: the array is written here for stores, and the
   // registered read launched here lands in time for the RESP state.
   assign access = (state_q == WAIT) && (cnt_q == 4'd0);
   assign arr_we = access && write_q && addr_good;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               cnt_d   = 4'(LATENCY);
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (cnt_q == 4'd0) begin
               err_d   = !addr_good;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         RESP: begin
            if (resp_ready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         err_q   <= err_d;
      end
   end

   dmem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (wstrb_q),
      .addr  (addr_q[ADDR_WIDTH+1:2]),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // The latched address and the array are untouched during RESP, so the
   // registered read data stays stable while the response is held. It is
   // gated to zero outside RESP and for stores/errors, which also makes the
   // output drop to zero as soon as reset clears the state.
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_error = err_q;
   assign resp_rdata = ((state_q == RESP) && !write_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;

   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;

   logic        req_valid0, req_ready0, req_write0;
   logic [31:0] req_addr0, req_wdata0;
   logic [3:0]  req_wstrb0;
   logic        resp_valid0, resp_ready0, resp_error0;
   logic [31:0] resp_rdata0;

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error)
   );

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid0),
      .req_ready  (req_ready0),
      .req_write  (req_write0),
      .req_addr   (req_addr0),
      .req_wdata  (req_wdata0),
      .req_wstrb  (req_wstrb0),
      .resp_valid (resp_valid0),
      .resp_ready (resp_ready0),
      .resp_rdata (resp_rdata0),
      .resp_error (resp_error0)
   );

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];
   logic [31:0] mdl [256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Computes the expected response from the bench's own memory model and
   // queues it, then drives the request until it is accepted.
   task automatic send(input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
      logic        err;
      logic [31:0] exp_rd;
      logic [7:0]  idx;
      int          n;
      err    = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
      exp_rd = 32'd0;
      idx    = a[9:2];
      if (!err) begin
         if (wr) begin
            for (int i = 0; i < 4; i++)
               if (st[i]) mdl[idx][8*i +: 8] = wd[8*i +: 8];
         end else begin
            exp_rd = mdl[idx];
         end
      end
      exp_q.push_back({err, exp_rd});
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      req_wstrb = st;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Waits for the response, checks latency, holds it for 'hold' cycles
   // checking stability, then completes the handshake.
   task automatic recv(input int hold, input int exp_lat);
      logic [32:0] e;
      int          n;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("resp_latency", 32'(n), 32'(exp_lat));
      e = exp_q.pop_front();
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", {31'd0, resp_valid}, 32'd1);
         check("hold_rdata", resp_rdata, e[31:0]);
         check("hold_error", {31'd0, resp_error}, {31'd0, e[32]});
         check("hold_req_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      check("resp_rdata", resp_rdata, e[31:0]);
      check("resp_error", {31'd0, resp_error}, {31'd0, e[32]});
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      check("post_valid", {31'd0, resp_valid}, 32'd0);
      check("post_rdata", resp_rdata, 32'd0);
      check("post_error", {31'd0, resp_error}, 32'd0);
      check("post_req_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0; req_wstrb  = '0;
      resp_ready  = 1'b0;
      req_valid0  = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_wstrb0 = '0;
      resp_ready0 = 1'b0;
      for (int i = 0; i < 256; i++) mdl[i] = 32'd0;

      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_error", {31'd0, resp_error}, 32'd0);
      reset = 1'b0;

      // store then load
      send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); recv(0, 3);
      send(1'b0, 32'h10, 32'h0, 4'h0);        recv(0, 3);

      // byte lanes and empty strobe
      send(1'b1, 32'h20, 32'h11223344, 4'hF); recv(0, 3);
      send(1'b1, 32'h20, 32'hAABBCCDD, 4'h5); recv(0, 3);
      send(1'b0, 32'h20, 32'h0, 4'h0);        recv(0, 3);
      send(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0); recv(0, 3);
      send(1'b0, 32'h20, 32'h0, 4'h0);        recv(0, 3);

      // error cases
      send(1'b0, 32'h22, 32'h0, 4'h0);        recv(0, 3);
      send(1'b1, 32'h0, 32'h0BADF00D, 4'hF);  recv(0, 3);
      send(1'b1, 32'h400, 32'h55555555, 4'hF); recv(0, 3);
      send(1'b0, 32'h0, 32'h0, 4'h0);         recv(0, 3);
      send(1'b0, 32'h80000000, 32'h0, 4'h0);  recv(0, 3);

      // backpressure with a competing request held valid
      send(1'b0, 32'h10, 32'h0, 4'h0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_wstrb = 4'h0;
      recv(5, 3);
      send(1'b0, 32'h20, 32'h0, 4'h0);        recv(0, 3);

      // reset while the store waits: it must never be committed
      send(1'b1, 32'h30, 32'hCAFEF00D, 4'hF); recv(0, 3);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
      req_wdata = 32'h12345678; req_wstrb = 4'hF;
      check("abort_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("midrst_resp_rdata", resp_rdata, 32'd0);
      check("midrst_resp_error", {31'd0, resp_error}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send(1'b0, 32'h30, 32'h0, 4'h0);        recv(0, 3);

      // zero latency: one request every 3 cycles with the consumer always ready
      @(negedge clk);
      req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h40;
      req_wdata0 = 32'h5A5A1234; req_wstrb0 = 4'hF; resp_ready0 = 1'b1;
      for (int k = 0; k < 9; k++) begin
         check("lat0_req_ready", {31'd0, req_ready0}, (k % 3 == 0) ? 32'd1 : 32'd0);
         check("lat0_resp_valid", {31'd0, resp_valid0}, (k % 3 == 2) ? 32'd1 : 32'd0);
         if (k % 3 == 2) begin
            check("lat0_rdata", resp_rdata0, 32'd0);
            check("lat0_error", {31'd0, resp_error0}, 32'd0);
         end
         @(negedge clk);
      end
      req_valid0 = 1'b0;

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
